// File: rtl/hash_ctrl_fsm_p.sv
// Hash-session controller: sequences IV load, per-word rounds and length-keyed finalisation.
// Optional abort port pair enabled with `define HASH_CTRL_ABORT_EN.
module hash_ctrl_fsm_p #(
  parameter int BYTES_PER_WORD  = 4,
  parameter int ROUNDS_PER_WORD = 4,
  parameter int FINAL_ROUNDS    = 4,
  parameter int LEN_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             empty_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_last_i,
  input  logic [3:0]       in_nbytes_i,
  output logic             init_h_o,
  output logic             load_word_o,
  output logic             round_en_o,
  output logic [2:0]       round_idx_o,
  output logic             use_counter_o,
  output logic             final_active_o,
  output logic [LEN_W-1:0] msg_len_o,
  output logic             len_ovf_o,
  output logic             digest_valid_o,
  input  logic             digest_ready_i,
  output logic             busy_o,
`ifdef HASH_CTRL_ABORT_EN
  input  logic             abort_i,
  output logic             aborted_o,
`endif
  output logic [2:0]       state_o
);

  localparam int MAXR = (ROUNDS_PER_WORD > FINAL_ROUNDS) ? ROUNDS_PER_WORD : FINAL_ROUNDS;
  localparam int CW   = ($clog2(MAXR) > 3) ? $clog2(MAXR) : 3;
  localparam logic [CW-1:0] RW_LAST = CW'(ROUNDS_PER_WORD - 1);
  localparam logic [CW-1:0] FR_LAST = CW'(FINAL_ROUNDS - 1);
  localparam logic [3:0]    BPW     = 4'(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             last_q, last_d;
  logic             empty_q, empty_d;
  logic             abort_req;
  logic [3:0]       add_bytes;
  logic [LEN_W:0]   len_sum;

`ifdef HASH_CTRL_ABORT_EN
  logic aborted_q;
  assign abort_req = abort_i && (state_q != S_IDLE);
  assign aborted_o = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  // Out-of-range byte counts (0 or above the word size) count as a full word.
  always_comb begin
    add_bytes = BPW;
    if (in_last_i && (in_nbytes_i != 4'd0) && (in_nbytes_i <= BPW))
      add_bytes = in_nbytes_i;
    len_sum = {1'b0, len_q} + {{(LEN_W-3){1'b0}}, add_bytes};
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    ovf_d          = ovf_q;
    last_d         = last_q;
    empty_d        = empty_q;
    in_ready_o     = 1'b0;
    init_h_o       = 1'b0;
    load_word_o    = 1'b0;
    round_en_o     = 1'b0;
    round_idx_o    = 3'd0;
    use_counter_o  = 1'b0;
    final_active_o = 1'b0;
    digest_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          empty_d = empty_i;
          len_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        init_h_o = 1'b1;
        cnt_d    = '0;
        state_d  = empty_q ? S_FINAL : S_LOAD;
      end
      S_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          load_word_o = 1'b1;
          len_d       = len_sum[LEN_W-1:0];
          if (len_sum[LEN_W])
            ovf_d = 1'b1;
          last_d  = in_last_i;
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        round_en_o  = 1'b1;
        round_idx_o = cnt_q[2:0];
        if (cnt_q == RW_LAST) begin
          cnt_d   = '0;
          state_d = last_q ? S_FINAL : S_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINAL: begin
        round_en_o     = 1'b1;
        round_idx_o    = cnt_q[2:0];
        use_counter_o  = 1'b1;
        final_active_o = 1'b1;
        if (cnt_q == FR_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        digest_valid_o = 1'b1;
        if (digest_ready_i)
          state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition computed above, including the DONE handshake.
    if (abort_req) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      empty_q <= empty_d;
    end
  end

`ifdef HASH_CTRL_ABORT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      aborted_q <= 1'b0;
    else
      aborted_q <= abort_req;
  end
`endif

  assign msg_len_o = len_q;
  assign len_ovf_o = ovf_q;
  assign busy_o    = (state_q != S_IDLE);
  assign state_o   = state_q;

endmodule

// File: tb/tb_hash_ctrl_fsm_p.sv
// Directed bench for hash_ctrl_fsm_p: per-cycle vector table plus hand-written multi-cycle sequences.
// A second instance with LEN_W=4 exercises length wrap-around.
module tb_hash_ctrl_fsm_p;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start, empty, in_valid, in_last, digest_ready;
  logic [3:0] in_nbytes;
  logic       in_ready, init_h, load_word, round_en, use_counter, final_active;
  logic       len_ovf, digest_valid, busy;
  logic [2:0] round_idx, state;
  logic [15:0] msg_len;
  logic       in_ready_w, init_h_w, load_word_w, round_en_w, use_counter_w, final_active_w;
  logic       len_ovf_w, digest_valid_w, busy_w;
  logic [2:0] round_idx_w, state_w;
  logic [3:0] msg_len_w;
`ifdef HASH_CTRL_ABORT_EN
  logic abort, aborted, aborted_w;
`endif

  hash_ctrl_fsm_p dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .empty_i(empty),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last), .in_nbytes_i(in_nbytes),
    .init_h_o(init_h), .load_word_o(load_word), .round_en_o(round_en), .round_idx_o(round_idx),
    .use_counter_o(use_counter), .final_active_o(final_active), .msg_len_o(msg_len),
    .len_ovf_o(len_ovf), .digest_valid_o(digest_valid), .digest_ready_i(digest_ready),
    .busy_o(busy),
`ifdef HASH_CTRL_ABORT_EN
    .abort_i(abort), .aborted_o(aborted),
`endif
    .state_o(state)
  );

  hash_ctrl_fsm_p #(.LEN_W(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .start_i(start), .empty_i(empty),
    .in_valid_i(in_valid), .in_ready_o(in_ready_w), .in_last_i(in_last), .in_nbytes_i(in_nbytes),
    .init_h_o(init_h_w), .load_word_o(load_word_w), .round_en_o(round_en_w), .round_idx_o(round_idx_w),
    .use_counter_o(use_counter_w), .final_active_o(final_active_w), .msg_len_o(msg_len_w),
    .len_ovf_o(len_ovf_w), .digest_valid_o(digest_valid_w), .digest_ready_i(digest_ready),
    .busy_o(busy_w),
`ifdef HASH_CTRL_ABORT_EN
    .abort_i(abort), .aborted_o(aborted_w),
`endif
    .state_o(state_w)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // {in_ready, load_word, init_h, round_en, use_counter, final_active, digest_valid, busy}
  function automatic logic [7:0] flags();
    return {in_ready, load_word, init_h, round_en, use_counter, final_active, digest_valid, busy};
  endfunction

  localparam logic [7:0] F_IDLE  = 8'h00;
  localparam logic [7:0] F_INIT  = 8'h21;
  localparam logic [7:0] F_LOADW = 8'h81;
  localparam logic [7:0] F_LOADV = 8'hC1;
  localparam logic [7:0] F_ROUND = 8'h11;
  localparam logic [7:0] F_FINAL = 8'h1D;
  localparam logic [7:0] F_DONE  = 8'h03;

  typedef struct {
    logic        start, empty, valid, last;
    logic [3:0]  nb;
    logic        dready;
    logic [2:0]  st;
    logic [7:0]  fl;
    logic [2:0]  idx;
    logic [15:0] len;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic e, input logic v, input logic l,
                              input logic [3:0] nb, input logic dr, input logic [2:0] st,
                              input logic [7:0] fl, input logic [2:0] idx, input logic [15:0] len);
    vec_t r;
    r.start = s; r.empty = e; r.valid = v; r.last = l; r.nb = nb; r.dready = dr;
    r.st = st; r.fl = fl; r.idx = idx; r.len = len;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_word(input logic last, input logic [3:0] nb);
    int k = 0;
    in_valid = 1'b0;
    #1;
    while (!in_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("ready_wait", 32'(k < 20), 32'd1);
    in_valid = 1'b1; in_last = last; in_nbytes = nb;
    #1;
    chk("load_word", 32'(load_word), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_nbytes = 4'd0;
  endtask

  task automatic wait_done();
    int k = 0;
    #1;
    while (!digest_valid && k < 100) begin
      @(negedge clk); #1; k++;
    end
    chk("done_wait", 32'(k < 100), 32'd1);
  endtask

  task automatic release_digest();
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; empty = 0; in_valid = 0; in_last = 0; in_nbytes = 0; digest_ready = 0;
`ifdef HASH_CTRL_ABORT_EN
    abort = 0;
`endif
    // Vector table: empty message, one clamped (nb=0) word, one clamped (nb=7) word.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3'd0, F_IDLE, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd1, F_INIT, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd4, F_FINAL, 3'(i), 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd5, F_DONE, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3'd5, F_DONE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3'd0, F_IDLE, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd1, F_INIT, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd2, F_LOADW, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 3'd2, F_LOADV, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(i == 1, i == 1, 0, 0, 0, 0, 3'd3, F_ROUND, 3'(i), 16'd4));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd4, F_FINAL, 3'(i), 16'd4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3'd5, F_DONE, 0, 16'd4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3'd0, F_IDLE, 0, 16'd4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd1, F_INIT, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4'd7, 0, 3'd2, F_LOADV, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd3, F_ROUND, 3'(i), 16'd4));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd4, F_FINAL, 3'(i), 16'd4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3'd5, F_DONE, 0, 16'd4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3'd0, F_IDLE, 0, 16'd4));

    // Reset state
    @(negedge clk); #1;
    chk("rst_flags", 32'(flags()), 32'(F_IDLE));
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_idx", 32'(round_idx), 32'd0);
    chk("rst_len", 32'(msg_len), 32'd0);
    chk("rst_ovf", 32'(len_ovf), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      start = tbl[i].start; empty = tbl[i].empty; in_valid = tbl[i].valid;
      in_last = tbl[i].last; in_nbytes = tbl[i].nb; digest_ready = tbl[i].dready;
      #1;
      chk($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("row%0d_flags", i), 32'(flags()), 32'(tbl[i].fl));
      chk($sformatf("row%0d_idx", i), 32'(round_idx), 32'(tbl[i].idx));
      chk($sformatf("row%0d_len", i), 32'(msg_len), 32'(tbl[i].len));
      chk($sformatf("row%0d_len4", i), 32'(msg_len_w), 32'(tbl[i].len[3:0]));
      $display("row %0d: state=%0d flags=%02h idx=%0d len=%0d", i, state, flags(), round_idx, msg_len);
      @(negedge clk);
    end
    start = 0; empty = 0; in_valid = 0; in_last = 0; in_nbytes = 0; digest_ready = 0;

    // Two full words (non-last nbytes ignored) plus a 3-byte last word, with a stall and backpressure.
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_state", 32'(state), 32'd2);
      chk("stall_ready", 32'(in_ready), 32'd1);
      chk("stall_round", 32'(round_en), 32'd0);
      tick();
    end
    for (int w = 0; w < 3; w++) begin
      send_word(w == 2, (w == 2) ? 4'd3 : 4'd1);
      for (int r = 0; r < 4; r++) begin
        #1;
        chk($sformatf("w%0d_r%0d_state", w, r), 32'(state), 32'd3);
        chk($sformatf("w%0d_r%0d_idx", w, r), 32'(round_idx), 32'(r));
        tick();
      end
    end
    for (int f = 0; f < 4; f++) begin
      #1;
      chk($sformatf("fin%0d_state", f), 32'(state), 32'd4);
      chk($sformatf("fin%0d_idx", f), 32'(round_idx), 32'(f));
      chk($sformatf("fin%0d_usecnt", f), 32'(use_counter), 32'd1);
      tick();
    end
    #1;
    chk("msg3_dv", 32'(digest_valid), 32'd1);
    chk("msg3_len", 32'(msg_len), 32'd11);
    $display("session 3-word: len=%0d dv=%0d", msg_len, digest_valid);
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_dv", 32'(digest_valid), 32'd1);
      chk("bp_len", 32'(msg_len), 32'd11);
      tick();
    end
    digest_ready = 1'b1; tick(); digest_ready = 1'b0; #1;
    chk("bp_idle", 32'(state), 32'd0);
    chk("bp_dv_low", 32'(digest_valid), 32'd0);
    chk("bp_len_kept", 32'(msg_len), 32'd11);
    $display("backpressure: state=%0d len=%0d", state, msg_len);
    tick();

    // Length wrap: 5 full words = 20 bytes.
    start = 1'b1; tick(); start = 1'b0;
    for (int w = 0; w < 5; w++) send_word(w == 4, 4'd4);
    wait_done();
    chk("wrap_len16", 32'(msg_len), 32'd20);
    chk("wrap_ovf16", 32'(len_ovf), 32'd0);
    chk("wrap_len4", 32'(msg_len_w), 32'd4);
    chk("wrap_ovf4", 32'(len_ovf_w), 32'd1);
    $display("wrap: len16=%0d len4=%0d ovf4=%0d", msg_len, msg_len_w, len_ovf_w);
    release_digest();
    start = 1'b1; tick(); start = 1'b0; #1;
    chk("wrap_clr_len4", 32'(msg_len_w), 32'd0);
    chk("wrap_clr_ovf4", 32'(len_ovf_w), 32'd0);
    send_word(1'b1, 4'd2);
    wait_done();
    chk("short_len", 32'(msg_len), 32'd2);
    release_digest();

    // Mid-ROUND asynchronous reset.
    start = 1'b1; tick(); start = 1'b0;
    send_word(1'b0, 4'd0);
    tick(); #1;
    chk("pre_rst_state", 32'(state), 32'd3);
    reset_n = 1'b0; #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_flags", 32'(flags()), 32'(F_IDLE));
    chk("async_rst_len", 32'(msg_len), 32'd0);
    @(negedge clk); reset_n = 1'b1; #1;
    chk("rel_flags", 32'(flags()), 32'(F_IDLE));
    tick(); #1;
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_flags2", 32'(flags()), 32'(F_IDLE));
    $display("mid-round reset: state=%0d", state);
    tick();

`ifdef HASH_CTRL_ABORT_EN
    // Abort during FINAL.
    start = 1'b1; tick(); start = 1'b0;
    send_word(1'b1, 4'd1);
    begin
      int k = 0;
      #1;
      while (state != 3'd4 && k < 20) begin tick(); #1; k++; end
      chk("abort_reach_final", 32'(k < 20), 32'd1);
    end
    abort = 1'b1; #1;
    chk("abort_pre", 32'(aborted), 32'd0);
    tick(); abort = 1'b0; #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_len", 32'(msg_len), 32'd0);
    chk("abort_dv", 32'(digest_valid), 32'd0);
    tick(); #1;
    chk("abort_pulse_end", 32'(aborted), 32'd0);
    chk("abort_dv2", 32'(digest_valid), 32'd0);
    $display("abort: state=%0d", state);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
